seg7_scan_ctrl: RTL and testbench

- Time-multiplexes one shared hex7seg decoder across NUM_DIGITS common-anode digits; the display shows the game score.
- Holds a double-buffered display value loaded through a valid/ready handshake, and commits new values only at frame boundaries, so a frame never tears.
- Scans the digits in order, with an all-off gap between digits to suppress ghosting.
- Optionally blanks leading zeros.

---
 rtl/seg7_scan_ctrl.sv | 146 ++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with a double-buffered display value.
// New values are committed only at frame boundaries so a frame never tears.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int SHOW_CYCLES = 100000,
  parameter int GAP_CYCLES  = 1000
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic                    load_valid_i,
  output logic                    load_ready_o,
  input  logic                    blank_lz_i,
  output logic [NUM_DIGITS-1:0]   anode_no,
  output logic [6:0]              segments_no
);

  localparam int MAXC = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0] SHOW_LAST = CW'(SHOW_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  typedef enum logic {
    ST_SHOW = 1'b0,
    ST_GAP  = 1'b1
  } state_t;

  // Active-high segment pattern {G,F,E,D,C,B,A} for one hex nibble.
  function automatic logic [6:0] hex7seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      4'hF:    seg = 7'h71;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

  state_t                  r_state;
  logic [IW-1:0]           r_idx;
  logic [CW-1:0]           r_cnt;
  logic [4*NUM_DIGITS-1:0] r_disp;
  logic [4*NUM_DIGITS-1:0] r_pend;
  logic                    r_pend_vld;

  logic                    w_frame_edge;
  logic [3:0]              w_nibble;
  logic [NUM_DIGITS-1:0]   w_zero_above;
  logic [NUM_DIGITS-1:0]   w_anode;

  assign w_frame_edge = (r_state == ST_GAP) && (r_cnt == GAP_LAST) && (r_idx == IDX_LAST);

  // Scan sequencer plus the pending/display double buffer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= ST_GAP;
      r_idx      <= IDX_LAST;
      r_cnt      <= '0;
      r_disp     <= '0;
      r_pend     <= '0;
      r_pend_vld <= 1'b0;
    end else begin
      case (r_state)
        ST_SHOW: begin
          if (r_cnt == SHOW_LAST) begin
            r_state <= ST_GAP;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_GAP: begin
          if (r_cnt == GAP_LAST) begin
            r_state <= ST_SHOW;
            r_cnt   <= '0;
            r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= ST_GAP;
          r_cnt   <= '0;
          r_idx   <= IDX_LAST;
        end
      endcase

      // Ready is low while pending, so a commit edge can never also accept.
      if (w_frame_edge && r_pend_vld) begin
        r_disp     <= r_pend;
        r_pend_vld <= 1'b0;
      end else if (load_valid_i && !r_pend_vld) begin
        r_pend     <= value_i;
        r_pend_vld <= 1'b1;
      end else begin
        r_pend_vld <= r_pend_vld;
      end
    end
  end

  // Digit select, leading-zero detection and anode gating.
  always_comb begin
    logic v_acc;
    w_nibble     = 4'h0;
    w_zero_above = '0;
    w_anode      = '1;
    v_acc        = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IW'(i)) begin
        w_nibble = r_disp[4*i +: 4];
      end else begin
        w_nibble = w_nibble;
      end
    end
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      v_acc           = v_acc & (r_disp[4*i +: 4] == 4'h0);
      w_zero_above[i] = v_acc;
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_anode[i] = ~((r_state == ST_SHOW) && (r_idx == IW'(i)) &&
                     !(blank_lz_i && (i != 0) && w_zero_above[i]));
    end
  end

  assign anode_no     = w_anode;
  assign segments_no  = ~hex7seg(w_nibble);
  assign load_ready_o = ~r_pend_vld;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: stimulus queues cycle-stamped expectations,
// a negedge monitor pops and compares them as the DUT reaches each cycle.
module tb_seg7_scan_ctrl;

  localparam int ND = 4;

  localparam logic [6:0] SG0 = 7'b1000000;
  localparam logic [6:0] SG1 = 7'b1111001;
  localparam logic [6:0] SG2 = 7'b0100100;
  localparam logic [6:0] SG3 = 7'b0110000;
  localparam logic [6:0] SG4 = 7'b0011001;
  localparam logic [6:0] SGA = 7'b0001000;
  localparam logic [6:0] SGF = 7'b0001110;
  localparam logic [6:0] SGX = 7'b0000000;

  logic            clk;
  logic            rst_ni;
  logic [4*ND-1:0] value_i;
  logic            load_valid_i;
  logic            load_ready_o;
  logic            blank_lz_i;
  logic [ND-1:0]   anode_no;
  logic [6:0]      segments_no;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int            cyc;
    logic [3:0]    an;
    logic [6:0]    seg;
    bit            cs;
    logic          rdy;
    bit            cr;
    logic [95:0]   nm;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;

  seg7_scan_ctrl #(
    .NUM_DIGITS (ND),
    .SHOW_CYCLES(4),
    .GAP_CYCLES (2)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .value_i     (value_i),
    .load_valid_i(load_valid_i),
    .load_ready_o(load_ready_o),
    .blank_lz_i  (blank_lz_i),
    .anode_no    (anode_no),
    .segments_no (segments_no)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_ni) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  task automatic check(input logic [95:0] nm, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %0s cyc=%0d actual=%b required=%b", nm, cyc, act, req);
    end
  endtask

  task automatic ex(input int c, input logic [3:0] an, input logic [6:0] seg, input bit cs,
                    input logic rdy, input bit cr, input logic [95:0] nm);
    exp_t x;
    x.cyc = c; x.an = an; x.seg = seg; x.cs = cs; x.rdy = rdy; x.cr = cr; x.nm = nm;
    sb_q.push_back(x);
  endtask

  // Monitor: compare every expectation due at this cycle.
  always @(negedge clk) begin
    if (rst_ni) begin
      for (int i = sb_q.size() - 1; i >= 0; i--) begin
        if (sb_q[i].cyc <= cyc) begin
          e = sb_q[i];
          if (e.cyc < cyc) begin
            total++;
            bad++;
            $display("FAIL %0s missed: due cyc=%0d now=%0d", e.nm, e.cyc, cyc);
          end else begin
            check(e.nm, {12'h000, anode_no}, {12'h000, e.an});
            if (e.cs) check(e.nm, {9'h000, segments_no}, {9'h000, e.seg});
            if (e.cr) check(e.nm, {15'h0000, load_ready_o}, {15'h0000, e.rdy});
          end
          sb_q.delete(i);
        end
      end
    end
  end

  task automatic wait_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_ni = 1'b1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: actual=%0d pending expectations required=0", sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    rst_ni       = 1'b0;
    value_i      = '0;
    load_valid_i = 1'b0;
    blank_lz_i   = 1'b0;

    // Plain scan after reset, display reads 0.
    do_reset();
    ex(0,  4'b1111, SGX, 0, 1'b1, 1, "t1_rst");
    ex(1,  4'b1111, SGX, 0, 1'b1, 1, "t1_gap0");
    ex(2,  4'b1110, SG0, 1, 1'b1, 1, "t1_d0a");
    ex(5,  4'b1110, SG0, 1, 1'b1, 0, "t1_d0b");
    ex(6,  4'b1111, SGX, 0, 1'b1, 0, "t1_gap1");
    ex(7,  4'b1111, SGX, 0, 1'b1, 0, "t1_gap2");
    ex(8,  4'b1101, SG0, 1, 1'b1, 0, "t1_d1a");
    ex(11, 4'b1101, SG0, 1, 1'b1, 0, "t1_d1b");
    ex(12, 4'b1111, SGX, 0, 1'b1, 0, "t1_gap3");
    ex(14, 4'b1011, SG0, 1, 1'b1, 0, "t1_d2");
    ex(20, 4'b0111, SG0, 1, 1'b1, 0, "t1_d3");
    ex(24, 4'b1111, SGX, 0, 1'b1, 0, "t1_gap4");
    ex(26, 4'b1110, SG0, 1, 1'b1, 1, "t1_f1d0");
    wait_to(27);
    drain();

    // Load at release, commit at the first frame boundary.
    do_reset();
    value_i      = 16'h1A3F;
    load_valid_i = 1'b1;
    ex(0,  4'b1111, SGX, 0, 1'b1, 1, "t2_rdy0");
    ex(1,  4'b1111, SGX, 0, 1'b0, 1, "t2_pend");
    ex(2,  4'b1110, SGF, 1, 1'b1, 1, "t2_d0F");
    ex(5,  4'b1110, SGF, 1, 1'b1, 0, "t2_d0Fb");
    ex(6,  4'b1111, SGX, 0, 1'b1, 1, "t2_gap");
    ex(8,  4'b1101, SG3, 1, 1'b1, 0, "t2_d1_3");
    wait_to(1);
    load_valid_i = 1'b0;
    value_i      = '0;

    // Mid-frame load with blanking: old value holds until the boundary.
    wait_to(10);
    blank_lz_i   = 1'b1;
    value_i      = 16'h0042;
    load_valid_i = 1'b1;
    ex(11, 4'b1101, SG3, 1, 1'b0, 1, "t3_hold1");
    ex(14, 4'b1011, SGA, 1, 1'b0, 1, "t3_holdA");
    ex(20, 4'b0111, SG1, 1, 1'b0, 0, "t3_hold_1");
    ex(25, 4'b1111, SGX, 0, 1'b0, 1, "t3_prebnd");
    ex(26, 4'b1110, SG2, 1, 1'b1, 1, "t3_d0_2");
    ex(32, 4'b1101, SG4, 1, 1'b1, 0, "t3_d1_4");
    ex(38, 4'b1111, SG0, 1, 1'b1, 0, "t3_blk2a");
    ex(41, 4'b1111, SGX, 0, 1'b1, 0, "t3_blk2b");
    ex(44, 4'b1111, SGX, 0, 1'b1, 0, "t3_blk3a");
    ex(47, 4'b1111, SGX, 0, 1'b1, 0, "t3_blk3b");
    ex(50, 4'b1110, SG2, 1, 1'b1, 0, "t3_f2d0");
    wait_to(11);
    load_valid_i = 1'b0;

    // Back-to-back loads: the second waits for the commit.
    wait_to(52);
    value_i      = 16'h1111;
    load_valid_i = 1'b1;
    ex(53, 4'b1110, SG2, 1, 1'b0, 1, "t4_acc1");
    wait_to(53);
    value_i = 16'h2222;
    ex(60, 4'b1111, SGX, 0, 1'b0, 1, "t4_bp1");
    ex(73, 4'b1111, SGX, 0, 1'b0, 1, "t4_bp2");
    ex(74, 4'b1110, SG1, 1, 1'b1, 1, "t4_cmt1");
    ex(75, 4'b1110, SG1, 1, 1'b0, 1, "t4_acc2");
    ex(80, 4'b1101, SG1, 1, 1'b0, 0, "t4_d1_1");
    ex(92, 4'b0111, SG1, 1, 1'b0, 0, "t4_d3_1");
    ex(97, 4'b1111, SGX, 0, 1'b0, 1, "t4_pre2");
    ex(98, 4'b1110, SG2, 1, 1'b1, 1, "t4_cmt2");
    wait_to(75);
    load_valid_i = 1'b0;
    value_i      = '0;

    // Reset mid-SHOW with a value pending.
    wait_to(99);
    value_i      = 16'h5555;
    load_valid_i = 1'b1;
    ex(100, 4'b1110, SG2, 1, 1'b0, 1, "t6_pend");
    wait_to(100);
    load_valid_i = 1'b0;
    blank_lz_i   = 1'b0;
    wait_to(101);
    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL t6_queue: actual=%0d left required=0", sb_q.size());
      sb_q.delete();
    end
    rst_ni = 1'b0;
    #1;
    check("t6_async_an", {12'h000, anode_no}, 16'h000F);
    check("t6_async_rd", {15'h0000, load_ready_o}, 16'h0001);
    check("t6_async_sg", {9'h000, segments_no}, {9'h000, SG0});
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    ex(0,  4'b1111, SGX, 0, 1'b1, 1, "t6_rel");
    ex(2,  4'b1110, SG0, 1, 1'b1, 1, "t6_d0");
    ex(8,  4'b1101, SG0, 1, 1'b1, 0, "t6_d1");
    ex(26, 4'b1110, SG0, 1, 1'b1, 1, "t6_f1d0");
    wait_to(27);
    drain();

    // Zero value with blanking, then blanking released live.
    blank_lz_i = 1'b1;
    do_reset();
    ex(2,  4'b1110, SG0, 1, 1'b1, 1, "t5_d0");
    ex(8,  4'b1111, SG0, 1, 1'b1, 0, "t5_blk1");
    ex(14, 4'b1111, SGX, 0, 1'b1, 0, "t5_blk2");
    ex(20, 4'b1111, SGX, 0, 1'b1, 0, "t5_blk3a");
    ex(21, 4'b1111, SGX, 0, 1'b1, 0, "t5_blk3b");
    wait_to(22);
    blank_lz_i = 1'b0;
    ex(22, 4'b0111, SG0, 1, 1'b1, 0, "t5_live3");
    ex(26, 4'b1110, SG0, 1, 1'b1, 0, "t5_z0");
    ex(32, 4'b1101, SG0, 1, 1'b1, 0, "t5_z1");
    ex(38, 4'b1011, SG0, 1, 1'b1, 0, "t5_z2");
    ex(44, 4'b0111, SG0, 1, 1'b1, 0, "t5_z3");
    wait_to(45);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
